// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module      : alu_seq
// Description : Sequential unsigned ALU. Add, subtract, compare and illegal
//               ops finish one cycle after acceptance; multiply (shift-add)
//               and the optional divide (restoring) take WIDTH cycles.
//               Define ALU_SEQ_DIV_EN to build the divider (op 3'b100);
//               without it op 3'b100 is reported as illegal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [2:0] OP_DIV = 3'b100;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic               pend_q, pend_d;   // a single-cycle op was accepted last edge
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
`endif

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign err    = err_q;

  // Next-state logic: finish pending work first, then accept a new request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    pend_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;

    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
`endif

    if (pend_q) begin
      done_d = 1'b1;
      case (op_q)
        OP_ADD: begin
          result_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
          carry_d  = add_sum[WIDTH];
          err_d    = 1'b0;
        end
        OP_SUB: begin
          result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
          carry_d  = sub_diff[WIDTH];   // borrow out means a < b
          err_d    = 1'b0;
        end
        OP_CMP: begin
          result_d = {{(2*WIDTH-3){1'b0}}, (a_q < b_q), (a_q == b_q), (a_q > b_q)};
          carry_d  = 1'b0;
          err_d    = 1'b0;
        end
        default: begin
          result_d = '0;
          carry_d  = 1'b0;
          err_d    = 1'b1;
        end
      endcase
    end

    case (state_q)
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          result_d = {mul_sum, acc_q[WIDTH-1:1]};
          carry_d  = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        // Dividing by zero naturally yields an all-ones quotient and remainder a.
        acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          result_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          carry_d  = 1'b0;
          err_d    = (b_q == '0);
          done_d   = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    if (start && (state_q == S_IDLE)) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      cnt_d = '0;
      if (op == OP_MUL) begin
        state_d = S_MUL;
        acc_d   = {{WIDTH{1'b0}}, b};
`ifdef ALU_SEQ_DIV_EN
      end else if (op == OP_DIV) begin
        state_d = S_DIV;
        acc_d   = {{WIDTH{1'b0}}, a};
`endif
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq with an arithmetic reference
//               model, directed literal cases and randomized traffic.
//               Honours ALU_SEQ_DIV_EN the same way as the design.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int W  = 4;
  localparam int RW = 2 * W;
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, carry, err;
  logic [RW-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one operation from plain arithmetic.
  function automatic void model_op(input int o, input int x, input int y,
                                   output logic [RW-1:0] r, output logic c,
                                   output logic e, output int lat);
    r = '0; c = 1'b0; e = 1'b0; lat = 1;
    case (o)
      0: begin r = RW'((x + y) % M); c = ((x + y) >= M); end
      1: begin r = RW'((x - y + M) % M); c = (x < y); end
      2: begin r = RW'(x * y); lat = W; end
      3: r = RW'((x > y ? 1 : 0) + (x == y ? 2 : 0) + (x < y ? 4 : 0));
`ifdef ALU_SEQ_DIV_EN
      4: begin
        lat = W;
        if (y == 0) begin r = RW'(x * M + (M - 1)); e = 1'b1; end
        else        r = RW'((x % y) * M + x / y);
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Reference model: one outstanding request, due a fixed latency after acceptance.
  int            cyc = 0;
  int            m_due = 0;
  int            m_lat = 0;
  bit            m_pend = 1'b0;
  bit            m_multi = 1'b0;
  bit            was_busy = 1'b0;
  logic          m_done = 1'b0, m_busy = 1'b0, m_car = 1'b0, m_err = 1'b0;
  logic          n_car = 1'b0, n_err = 1'b0;
  logic [RW-1:0] m_res = '0, n_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1'b0; m_multi = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      m_res = '0; m_car = 1'b0; m_err = 1'b0;
    end else begin
      was_busy = m_busy;
      cyc++;
      m_done = 1'b0;
      if (m_pend && cyc == m_due) begin
        m_res = n_res; m_car = n_car; m_err = n_err;
        m_done = 1'b1; m_pend = 1'b0;
      end
      if (start && !was_busy) begin
        model_op(int'(op), int'(a), int'(b), n_res, n_car, n_err, m_lat);
        m_pend  = 1'b1;
        m_due   = cyc + m_lat;
        m_multi = (m_lat > 1);
      end
      m_busy = m_pend && m_multi;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done",   done,   m_done);
      check("busy",   busy,   m_busy);
      check("result", result, m_res);
      check("carry",  carry,  m_car);
      check("err",    err,    m_err);
    end
  end

  // Issue one request (called at a negedge), scramble operands, wait for done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, output logic [RW-1:0] r, output logic c,
                        output logic e, output int lat, output int bc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0;
    bc = int'(busy);
    do begin
      @(negedge clk);
      lat++;
      if (!done && busy) bc++;
      start = poke && (lat == 1) && !done;
      if (start) begin op = 3'd0; a = W'($urandom); b = W'($urandom); end
    end while (!done && lat < 40);
    start = 1'b0;
    if (lat >= 40) check("done_timeout", 64'(lat), 64'(0));
    r = result; c = carry; e = err;
  endtask

  logic [RW-1:0] r;
  logic          c, e;
  int            lat, bc, cnt;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, '0);
    check("rst_carry", carry, 1'b0);
    check("rst_err", err, 1'b0);

    // First request on the first rising edge after release.
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_op(3'b000, 4'd9, 4'd8, 1'b0, r, c, e, lat, bc);
    check("add_result", r, 8'h01);
    check("add_carry", c, 1'b1);
    check("add_err", e, 1'b0);
    check("add_latency", lat, 1);

    run_op(3'b001, 4'd3, 4'd5, 1'b0, r, c, e, lat, bc);
    check("sub_result", r, 8'h0E);
    check("sub_borrow", c, 1'b1);

    run_op(3'b011, 4'd7, 4'd7, 1'b0, r, c, e, lat, bc);
    check("cmp_result", r, 8'h02);

    run_op(3'b010, 4'd15, 4'd15, 1'b1, r, c, e, lat, bc);
    check("mul_result", r, 8'hE1);
    check("mul_latency", lat, 4);
    check("mul_busy_cycles", bc, 4);

`ifdef ALU_SEQ_DIV_EN
    run_op(3'b100, 4'd13, 4'd4, 1'b0, r, c, e, lat, bc);
    check("div_result", r, 8'h13);
    check("div_latency", lat, 4);
    check("div_err", e, 1'b0);
    run_op(3'b100, 4'd6, 4'd0, 1'b0, r, c, e, lat, bc);
    check("div0_result", r, 8'h6F);
    check("div0_err", e, 1'b1);
`else
    run_op(3'b100, 4'd13, 4'd4, 1'b0, r, c, e, lat, bc);
    check("op4_result", r, 8'h00);
    check("op4_err", e, 1'b1);
    check("op4_latency", lat, 1);
`endif

    run_op(3'b111, 4'd3, 4'd4, 1'b0, r, c, e, lat, bc);
    check("illegal_result", r, 8'h00);
    check("illegal_err", e, 1'b1);

    // Abort a multiply two cycles in.
    start = 1'b1; op = 3'b010; a = 4'd11; b = 4'd13;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, '0);
    check("abort_carry", carry, 1'b0);
    check("abort_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 4'd5, 4'd6, 1'b0, r, c, e, lat, bc);
    check("post_reset_add", r, 8'h0B);
    check("post_reset_latency", lat, 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // Start held high with adds: one done per cycle.
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (done) cnt++;
      start = (i < 8);
      op = 3'b000; a = W'($urandom); b = W'($urandom);
    end
    check("back_to_back_dones", cnt, 8);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      a     = W'($urandom);
      b     = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
